// File: rtl/packer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : packer_pkg
//  Description : Shared widths and chunk-ordering helpers for the pusher and
//                the packer, so both sides agree on slot placement.
//  Revision    : 1.0  initial release
// ============================================================================
package packer_pkg;

  localparam int DEF_BUS_WIDTH  = 32;
  localparam int DEF_DATA_WIDTH = 8;

  // Number of chunks that make up one bus word.
  function automatic int chunks(input int bus_w, input int data_w);
    return bus_w / data_w;
  endfunction

  // Width able to hold a chunk count from 0 up to and including chunks().
  function automatic int cnt_w(input int bus_w, input int data_w);
    return $clog2(bus_w / data_w) + 1;
  endfunction

  // MSB bit index of a slot; slot 0 is the most significant chunk.
  function automatic int slot_msb(input int slot, input int bus_w, input int data_w);
    return bus_w - 1 - slot * data_w;
  endfunction

  localparam int CHUNKS = chunks(DEF_BUS_WIDTH, DEF_DATA_WIDTH);
  localparam int CNT_W  = cnt_w(DEF_BUS_WIDTH, DEF_DATA_WIDTH);

endpackage
`default_nettype wire

// File: rtl/word_hold_reg.sv
`default_nettype none
// ============================================================================
//  Module      : word_hold_reg
//  Description : Single-entry valid/ready output register carrying an
//                assembled word, its chunk count and its early-close flag.
//                A new entry may load on the same edge the old one drains.
//  Revision    : 1.0  initial release
// ============================================================================
module word_hold_reg
  import packer_pkg::*;
#(
  parameter int DATA_W  = DEF_BUS_WIDTH,
  parameter int COUNT_W = CNT_W
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [DATA_W-1:0]  in_data_i,
  input  logic [COUNT_W-1:0] in_count_i,
  input  logic               in_last_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [DATA_W-1:0]  out_data_o,
  output logic [COUNT_W-1:0] out_count_o,
  output logic               out_last_o
);

  logic               r_valid;
  logic [DATA_W-1:0]  r_data;
  logic [COUNT_W-1:0] r_count;
  logic               r_last;

  assign in_ready_o  = !r_valid || out_ready_i;
  assign out_valid_o = r_valid;
  assign out_data_o  = r_data;
  assign out_count_o = r_count;
  assign out_last_o  = r_last;

  // Load on an accepted entry, otherwise drop valid once the consumer takes it;
  // payload is left untouched after a drain so it stays stable until the next load.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_count <= '0;
      r_last  <= 1'b0;
    end else if (in_valid_i && in_ready_o) begin
      r_valid <= 1'b1;
      r_data  <= in_data_i;
      r_count <= in_count_i;
      r_last  <= in_last_i;
    end else if (r_valid && out_ready_i) begin
      r_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/chunk_packer.sv
`default_nettype none
// ============================================================================
//  Module      : chunk_packer
//  Description : Width up-converter. Collects DATA_WIDTH chunks, most
//                significant first, into BUS_WIDTH words; last_i closes a
//                word early with the unfilled low slots zeroed.
//  Revision    : 1.0  initial release
// ============================================================================
module chunk_packer
  import packer_pkg::*;
#(
  parameter int BUS_WIDTH  = DEF_BUS_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                                        clk_i,
  input  logic                                        rst_ni,
  input  logic [DATA_WIDTH-1:0]                       data_i,
  input  logic                                        valid_i,
  input  logic                                        last_i,
  output logic                                        ready_o,
  output logic [BUS_WIDTH-1:0]                        data_o,
  output logic [cnt_w(BUS_WIDTH, DATA_WIDTH)-1:0]     count_o,
  output logic                                        last_o,
  output logic                                        valid_o,
  input  logic                                        ready_i
);

  localparam int                 C_CHUNKS   = chunks(BUS_WIDTH, DATA_WIDTH);
  localparam int                 C_CNT_W    = cnt_w(BUS_WIDTH, DATA_WIDTH);
  localparam logic [C_CNT_W-1:0] C_LAST_CNT = C_CNT_W'(C_CHUNKS - 1);

  // Fill counter: index of the slot the next accepted chunk lands in.
  logic [C_CNT_W-1:0]   r_cnt;
  logic [BUS_WIDTH-1:0] r_asm;

  logic                 w_hold_ready;
  logic                 w_accept;
  logic                 w_close;
  logic [BUS_WIDTH-1:0] w_word;
  logic [C_CNT_W-1:0]   w_count;
  logic                 w_last;

  // Reset gates ready so no chunk is claimed while the packer is held in reset.
  assign ready_o  = rst_ni && w_hold_ready;
  assign w_accept = valid_i && ready_o;
  assign w_close  = w_accept && ((r_cnt == C_LAST_CNT) || last_i);
  assign w_count  = r_cnt + C_CNT_W'(1);
  assign w_last   = last_i && (r_cnt != C_LAST_CNT);

  // Assembly value including the incoming chunk; slots after the current one
  // are forced to zero so an early-closed word is padded regardless of history.
  for (genvar k = 0; k < C_CHUNKS; k++) begin : g_slot
    localparam int                 C_MSB = slot_msb(k, BUS_WIDTH, DATA_WIDTH);
    localparam logic [C_CNT_W-1:0] C_IDX = C_CNT_W'(k);
    assign w_word[C_MSB -: DATA_WIDTH] =
      (r_cnt == C_IDX) ? data_i :
      (r_cnt >  C_IDX) ? r_asm[C_MSB -: DATA_WIDTH] : '0;
  end

  // Advance the fill counter per accepted chunk; restart from an empty word on close.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
      r_asm <= '0;
    end else if (w_close) begin
      r_cnt <= '0;
      r_asm <= '0;
    end else if (w_accept) begin
      r_cnt <= w_count;
      r_asm <= w_word;
    end
  end

  word_hold_reg #(
    .DATA_W  (BUS_WIDTH),
    .COUNT_W (C_CNT_W)
  ) u_hold (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (w_close),
    .in_ready_o  (w_hold_ready),
    .in_data_i   (w_word),
    .in_count_i  (w_count),
    .in_last_i   (w_last),
    .out_valid_o (valid_o),
    .out_ready_i (ready_i),
    .out_data_o  (data_o),
    .out_count_o (count_o),
    .out_last_o  (last_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_chunk_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_chunk_packer
//  Description : Directed and randomized self-checking bench for chunk_packer
//                (BUS_WIDTH 32, DATA_WIDTH 8).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_chunk_packer;

  logic        clk_i;
  logic        rst_ni;
  logic [7:0]  data_i;
  logic        valid_i;
  logic        last_i;
  logic        ready_o;
  logic [31:0] data_o;
  logic [2:0]  count_o;
  logic        last_o;
  logic        valid_o;
  logic        ready_i;

  int checks = 0;
  int errors = 0;

  chunk_packer #(.BUS_WIDTH(32), .DATA_WIDTH(8)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .data_i  (data_i),
    .valid_i (valid_i),
    .last_i  (last_i),
    .ready_o (ready_o),
    .data_o  (data_o),
    .count_o (count_o),
    .last_o  (last_o),
    .valid_o (valid_o),
    .ready_i (ready_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic l);
    valid_i = 1'b1;
    data_i  = d;
    last_i  = l;
    tick();
  endtask

  task automatic idle();
    valid_i = 1'b0;
    last_i  = 1'b0;
  endtask

  task automatic chk_word(input string tag, input logic [31:0] d, input logic [2:0] c, input logic l);
    chk({tag, "_valid"}, 64'(valid_o), 64'(1'b1));
    chk({tag, "_data"},  64'(data_o),  64'(d));
    chk({tag, "_count"}, 64'(count_o), 64'(c));
    chk({tag, "_last"},  64'(last_o),  64'(l));
  endtask

  // Scoreboard state for the randomized phase.
  logic [35:0] sb[$];
  logic [31:0] m_asm;
  int          m_cnt;
  logic        pend;
  logic [7:0]  pd;
  logic        pl;
  int          sent;
  int          cyc;
  logic        acc, drn, hold;
  logic [35:0] snap;
  logic [35:0] exp_w;

  initial begin
    rst_ni  = 1'b0;
    valid_i = 1'b0;
    data_i  = '0;
    last_i  = 1'b0;
    ready_i = 1'b1;
    #2;
    chk("rst_valid", 64'(valid_o), 64'(0));
    chk("rst_data",  64'(data_o),  64'(0));
    chk("rst_count", 64'(count_o), 64'(0));
    chk("rst_last",  64'(last_o),  64'(0));
    chk("rst_ready", 64'(ready_o), 64'(0));
    tick();
    rst_ni = 1'b1;
    #1;
    chk("post_rst_ready", 64'(ready_o), 64'(1));

    // Full word, one chunk per cycle.
    push(8'h0A, 0); push(8'hBA, 0); push(8'hCD, 0); push(8'hEF, 0);
    chk_word("w1", 32'h0ABACDEF, 3'd4, 1'b0);
    idle();
    tick();
    chk("w1_one_cycle", 64'(valid_o), 64'(0));

    // Early close, then an 8-chunk stream with no bubble.
    push(8'h11, 0); push(8'h22, 1);
    chk_word("w2", 32'h11220000, 3'd2, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      chk("stream_ready", 64'(ready_o), 64'(1));
      push(8'(i), 0);
      if (i == 4) chk_word("w3", 32'h01020304, 3'd4, 1'b0);
      if (i == 5) chk("w3_drained", 64'(valid_o), 64'(0));
      if (i == 8) chk_word("w4", 32'h05060708, 3'd4, 1'b0);
    end
    idle();
    tick();

    // Backpressure: word held, upstream stalls, drain and accept on one edge.
    ready_i = 1'b0;
    push(8'h21, 0); push(8'h22, 0); push(8'h23, 0); push(8'h24, 0);
    chk_word("w5", 32'h21222324, 3'd4, 1'b0);
    valid_i = 1'b1; data_i = 8'h55; last_i = 1'b0;
    #1;
    chk("stall_ready", 64'(ready_o), 64'(0));
    tick();
    chk_word("w5_held", 32'h21222324, 3'd4, 1'b0);
    ready_i = 1'b1;
    #1;
    chk("unstall_ready", 64'(ready_o), 64'(1));
    tick();
    chk("w5_drained", 64'(valid_o), 64'(0));
    push(8'h66, 0); push(8'h77, 0); push(8'h88, 0);
    chk_word("w6", 32'h55667788, 3'd4, 1'b0);
    idle();
    tick();

    // last_i on the final slot is an ordinary full word.
    push(8'h01, 0); push(8'h02, 0); push(8'h03, 0); push(8'h04, 1);
    chk_word("w7", 32'h01020304, 3'd4, 1'b0);
    idle();
    tick();

    // Mid-word asynchronous reset discards the partial word.
    push(8'hAA, 0); push(8'hBB, 0); push(8'hCC, 0);
    idle();
    #1 rst_ni = 1'b0;
    #1;
    chk("mid_rst_data",  64'(data_o),  64'(0));
    chk("mid_rst_count", 64'(count_o), 64'(0));
    chk("mid_rst_valid", 64'(valid_o), 64'(0));
    chk("mid_rst_ready", 64'(ready_o), 64'(0));
    #2 rst_ni = 1'b1;
    tick();
    push(8'hDD, 0); push(8'hEE, 0); push(8'hFF, 0); push(8'h01, 0);
    chk_word("w8", 32'hDDEEFF01, 3'd4, 1'b0);

    // Reset while a word is held undrained.
    ready_i = 1'b0;
    idle();
    tick();
    rst_ni = 1'b0;
    #1;
    chk("hold_rst_valid", 64'(valid_o), 64'(0));
    chk("hold_rst_data",  64'(data_o),  64'(0));
    ready_i = 1'b1;
    #1 rst_ni = 1'b1;
    tick();

    // Randomized handshakes against a scoreboard.
    m_asm = '0; m_cnt = 0; pend = 1'b0; pd = '0; pl = 1'b0; sent = 0; cyc = 0;
    while ((sent < 1000 || sb.size() != 0 || valid_o) && cyc < 20000) begin
      if (!pend && sent < 1000 && $urandom_range(0, 3) != 0) begin
        pend = 1'b1;
        pd   = 8'($urandom);
        pl   = (sent == 999) ? 1'b1 : ($urandom_range(0, 4) == 0);
      end
      valid_i = pend;
      data_i  = pd;
      last_i  = pl;
      ready_i = (sent >= 1000) ? 1'b1 : ($urandom_range(0, 3) != 0);
      #1;
      chk("rnd_ready", 64'(ready_o), 64'(!valid_o || ready_i));
      acc  = valid_i && ready_o;
      drn  = valid_o && ready_i;
      hold = valid_o && !ready_i;
      snap = {data_o, count_o, last_o};
      if (drn) begin
        exp_w = (sb.size() != 0) ? sb.pop_front() : 36'hF_FFFF_FFFF;
        chk("rnd_word", 64'(snap), 64'(exp_w));
      end
      tick();
      cyc++;
      if (acc) begin
        m_asm[31 - 8*m_cnt -: 8] = pd;
        if (m_cnt == 3 || pl) begin
          sb.push_back({m_asm, 3'(m_cnt + 1), pl && (m_cnt != 3)});
          m_asm = '0;
          m_cnt = 0;
        end else begin
          m_cnt++;
        end
        sent++;
        pend = 1'b0;
      end
      if (hold) begin
        chk("rnd_stall_valid", 64'(valid_o), 64'(1));
        chk("rnd_stall_word", 64'({data_o, count_o, last_o}), 64'(snap));
      end
    end
    idle();
    chk("rnd_sent", 64'(sent), 64'(1000));
    chk("rnd_sb_empty", 64'(sb.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/chunk_packer.md
# chunk_packer

Width up-converter that sits directly downstream of the pusher in the matrix-multiplier datapath. It collects DATA_WIDTH chunks arriving one per handshake, most-significant chunk first, and reassembles them into BUS_WIDTH words. It supports early termination with a zero-padded partial word. It exposes valid/ready on both sides so the word consumer can stall the chunk stream.

## Interface
- BUS_WIDTH, 32, assembled word width; must be an integer multiple of DATA_WIDTH
- DATA_WIDTH, 8, chunk width
- clk_i  in  1  single clock, rising edge
- rst_ni  in  1  asynchronous, active-low reset
- data_i  in  DATA_WIDTH  incoming chunk
- valid_i  in  1  data_i/last_i are valid
- last_i  in  1  this chunk ends the current word, even if the word is not full
- ready_o  out  1  packer accepts a chunk this cycle
- data_o  out  BUS_WIDTH  assembled word
- count_o  out  $clog2(CHUNKS)+1  number of valid chunks in data_o (1..CHUNKS)
- last_o  out  1  word was closed by last_i rather than by filling
- valid_o  out  1  data_o/count_o/last_o are valid
- ready_i  in  1  downstream accepts the word

## Operation
- CHUNKS = BUS_WIDTH/DATA_WIDTH.
- A chunk transfers when valid_i && ready_o on a rising edge.
- An accepted chunk is written to slot cnt:
  - slot 0 is bits [BUS_WIDTH-1 -: DATA_WIDTH];
  - slot k is bits [BUS_WIDTH-1-k*DATA_WIDTH -: DATA_WIDTH];
  - example: chunks 0A, BA, CD, EF give 32'h0ABACDEF.
- State machine:
  - FILL: cnt 0..CHUNKS-1 counts accepted chunks of the current word.
  - A word closes on an accepted chunk when cnt == CHUNKS-1 or last_i == 1.
  - On close:
    - the output register loads the assembly value with unfilled low slots forced to 0;
    - count_o = cnt+1;
    - last_o = last_i && (cnt != CHUNKS-1);
    - valid_o is set;
    - cnt returns to 0 and the assembly register clears.
- last_i on the CHUNKS-th chunk is a normal full word: last_o=0, count_o=CHUNKS.
- Output register is a single-entry hold stage:
  - valid_o stays high and data_o/count_o/last_o stay stable until valid_o && ready_i.
  - A new word may load in the same cycle the old one drains.
- ready_o = rst_ni && (!valid_o || ready_i). While the output holds an undrained word, no chunk is accepted, including non-closing chunks.
- valid_i without ready_o: no state change. The upstream must hold data_i/last_i.
- Reset, asynchronous, at any time including mid-word:
  - cnt=0, assembly=0;
  - data_o=0, count_o=0, last_o=0, valid_o=0;
  - ready_o=0 while rst_ni is low.
- Partially assembled chunks are discarded on reset and never emitted.

## Timing
- Latency: valid_o rises on the edge that accepts the closing chunk, so it is visible the following cycle.
- Throughput: one chunk per cycle sustained with ready_i held high. A full word emerges every CHUNKS cycles with no bubble.
- ready_o is combinational from valid_o and ready_i only. There is no path from valid_i or last_i to ready_o.
- All outputs except ready_o are registered.
- First chunk can be accepted on the first rising edge after rst_ni deasserts.
- Simultaneous closing-chunk accept and output drain: the old word leaves and the new word loads on the same edge, and valid_o stays 1.

## Structure
- Shared package `packer_pkg`:
  - default BUS_WIDTH/DATA_WIDTH;
  - CHUNKS and CNT_W = $clog2(CHUNKS)+1 as localparam functions;
  - a slot-offset function used by both packer and pusher to keep chunk ordering identical.
- One sub-module: `word_hold_reg`, a single-entry valid/ready register carrying {data, count, last}.
- The assembly counter and slot write logic live in chunk_packer.

## Test plan
- Reset, then chunks 0A,BA,CD,EF on consecutive cycles with ready_i=1 -> one cycle after EF accepted: data_o=32'h0ABACDEF, count_o=4, last_o=0, valid_o=1 for one cycle.
- Chunks 11,22 with last_i on 22 -> data_o=32'h11220000, count_o=2, last_o=1. A following 8-chunk stream yields two full words with no gap.
- Full word completed with ready_i=0 -> valid_o held with data stable and ready_o=0. Upstream holds chunk 55. Raise ready_i -> word drains and 55 is accepted in the same cycle, landing in slot 0 of the next word.
- Three chunks AA,BB,CC accepted, then rst_ni pulsed low mid-cycle -> all outputs 0 immediately. Then DD,EE,FF,01 -> 32'hDDEEFF01; no AA/BB/CC residue.
- last_i asserted on the 4th chunk 01,02,03,04 -> 32'h01020304, count_o=4, last_o=0.
- Random valid_i/ready_i toggling over 1000 chunks against a scoreboard model -> no loss, no duplication, outputs stable while stalled.
